// File: rtl/pll_supervisor_pkg.sv
// Shared definitions for the PLL supervisor family: FSM state encoding,
// SB_PLL40_CORE configuration defaults and a counter-sizing helper.
// No logic; imported by pll_supervisor and sibling pll_* wrappers.
package pll_supervisor_pkg;

  // Supervisor sequencing states
  typedef enum logic [2:0] {
    RST_PLL   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    READY     = 3'd3,
    FAULT     = 3'd4
  } sup_state_t;

  // SB_PLL40_CORE settings common to every pll_* wrapper
  localparam string      PLL_FEEDBACK_PATH = "SIMPLE";
  localparam string      PLL_OUT_SELECT    = "GENCLK";
  localparam logic [3:0] PLL_DIVR_DEFAULT  = 4'd0;
  localparam logic [6:0] PLL_DIVF_DEFAULT  = 7'd84;
  localparam logic [2:0] PLL_DIVQ_DEFAULT  = 3'd2;
  localparam logic [2:0] PLL_FILT_DEFAULT  = 3'd1;

  // Width of the shared phase counter: enough to count up to the longest phase minus one
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sb_pll40_core.sv
// Behavioural stand-in for the iCE40 SB_PLL40_CORE primitive, used for
// simulation and lint only; the FPGA build uses the vendor cell instead.
// Output clock follows the reference; LOCK rises 7 cycles after RESETB releases.
module SB_PLL40_CORE #(
  parameter             FEEDBACK_PATH = "SIMPLE",
  parameter             PLLOUT_SELECT = "GENCLK",
  parameter logic [3:0] DIVR          = 4'd0,
  parameter logic [6:0] DIVF          = 7'd0,
  parameter logic [2:0] DIVQ          = 3'd0,
  parameter logic [2:0] FILTER_RANGE  = 3'd0
) (
  input  logic REFERENCECLK,
  output logic PLLOUTCORE,
  output logic PLLOUTGLOBAL,
  output logic LOCK,
  input  logic BYPASS,
  input  logic RESETB
);

  logic [2:0] settle;
  logic       unused_cfg;

  // The divider settings shape the real analogue loop; this model ignores them
  assign unused_cfg = (^{DIVR, DIVF, DIVQ, FILTER_RANGE}) ^ (FEEDBACK_PATH == "SIMPLE")
                      ^ (PLLOUT_SELECT == "GENCLK");

  assign PLLOUTCORE   = REFERENCECLK;
  assign PLLOUTGLOBAL = REFERENCECLK;
  assign LOCK         = (settle == 3'd7) && !BYPASS;

  // Settling time after the loop is released from reset
  always_ff @(posedge REFERENCECLK or negedge RESETB) begin
    if (!RESETB) begin
      settle <= 3'd0;
    end else if (settle != 3'd7) begin
      settle <= settle + 3'd1;
    end
  end

endmodule

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single level signal into clk's domain.
// Latency: 2 clk cycles. No backpressure.
// Async reset drives the output to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Capture then re-time the asynchronous input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_supervisor.sv
// iCE40 PLL wrapper: sequences PLL reset, waits for lock with timeout/retries, debounces lock.
// Latency: ready appears 2 sync + 1 detect + STABLE_CYCLES cycles after LOCK is sampled high.
// No backpressure; ready/reset outputs are registered and change only on clock_in edges.
module pll_supervisor
  import pll_supervisor_pkg::*;
#(
  parameter logic [3:0] DIVR           = PLL_DIVR_DEFAULT,
  parameter logic [6:0] DIVF           = PLL_DIVF_DEFAULT,
  parameter logic [2:0] DIVQ           = PLL_DIVQ_DEFAULT,
  parameter logic [2:0] FILTER_RANGE   = PLL_FILT_DEFAULT,
  parameter int         RST_CYCLES     = 16,
  parameter int         STABLE_CYCLES  = 1024,
  parameter int         TIMEOUT_CYCLES = 65536,
  parameter int         MAX_RETRIES    = 3,
  parameter int         LOSS_W         = 8
) (
  input  logic              clock_in,
  input  logic              reset,
  output logic              clock_out,
  output logic              pll_ready,
  output logic              pll_reset_out,
  output logic              fault,
  output logic [3:0]        retry_count,
  output logic [LOSS_W-1:0] lock_loss_cnt
);

  localparam int CNT_W = cnt_width(RST_CYCLES, STABLE_CYCLES, TIMEOUT_CYCLES);

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

  sup_state_t        state;
  sup_state_t        state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [3:0]        retry_nxt;
  logic [LOSS_W-1:0] loss_nxt;
  logic              pll_lock;
  logic              lock_s;
  logic              pll_resetb;
  logic              unused_pll_global;

  SB_PLL40_CORE #(
    .FEEDBACK_PATH (PLL_FEEDBACK_PATH),
    .PLLOUT_SELECT (PLL_OUT_SELECT),
    .DIVR          (DIVR),
    .DIVF          (DIVF),
    .DIVQ          (DIVQ),
    .FILTER_RANGE  (FILTER_RANGE)
  ) u_pll (
    .REFERENCECLK (clock_in),
    .PLLOUTCORE   (clock_out),
    .PLLOUTGLOBAL (unused_pll_global),
    .LOCK         (pll_lock),
    .BYPASS       (1'b0),
    .RESETB       (pll_resetb)
  );

  sync_2ff u_lock_sync (
    .clk (clock_in),
    .rst (reset),
    .d   (pll_lock),
    .q   (lock_s)
  );

  // Next-state, retry and lock-loss decisions; lock always takes priority over timers
  always_comb begin
    state_nxt = state;
    retry_nxt = retry_count;
    loss_nxt  = lock_loss_cnt;
    case (state)
      RST_PLL: begin
        if (cnt == RST_LAST) state_nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = STABLE;
        end else if (cnt == TIMEOUT_LAST) begin
          retry_nxt = retry_count + 4'd1;
          state_nxt = (retry_nxt == RETRY_LIMIT) ? FAULT : RST_PLL;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = READY;
          retry_nxt = 4'd0;
        end
      end
      READY: begin
        if (!lock_s) begin
          state_nxt = RST_PLL;
          if (lock_loss_cnt != {LOSS_W{1'b1}}) loss_nxt = lock_loss_cnt + LOSS_W'(1);
        end
      end
      FAULT: begin
        state_nxt = FAULT;
      end
      default: begin
        state_nxt = RST_PLL;
      end
    endcase
  end

  // State, phase counter (cleared on every state change) and statistics registers
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state         <= RST_PLL;
      cnt           <= '0;
      retry_count   <= 4'd0;
      lock_loss_cnt <= '0;
    end else begin
      state         <= state_nxt;
      retry_count   <= retry_nxt;
      lock_loss_cnt <= loss_nxt;
      if (state_nxt != state) begin
        cnt <= '0;
      end else if (state != READY && state != FAULT) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Outputs registered from the next state so they move with the state register and never glitch
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      pll_ready     <= 1'b0;
      pll_reset_out <= 1'b1;
      fault         <= 1'b0;
      pll_resetb    <= 1'b0;
    end else begin
      pll_ready     <= (state_nxt == READY);
      pll_reset_out <= (state_nxt != READY);
      fault         <= (state_nxt == FAULT);
      pll_resetb    <= !((state_nxt == RST_PLL) || (state_nxt == FAULT));
    end
  end

endmodule

// File: tb/tb_pll_supervisor.sv
// Bench for pll_supervisor: LOCK is forced from here onto both instances (LOSS_W=8 and 2),
// a phase/age reference model derived from the sequencing rules predicts every output each
// cycle, and directed scenarios measure lock-to-ready, reset-pulse and timeout lengths.
module tb_pll_supervisor;

  localparam int RSTC = 4;
  localparam int STC  = 8;
  localparam int TOC  = 32;
  localparam int MAXR = 3;

  logic       clk;
  logic       rst;
  logic       co1, rdy1, pro1, flt1;
  logic [3:0] rc1;
  logic [7:0] llc1;
  logic       co2, rdy2, pro2, flt2;
  logic [3:0] rc2;
  logic [1:0] llc2;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  string m_phase;
  int    m_age;
  int    m_retry;
  int    m_loss;
  bit    m_sync[$];
  bit    lock_drv;

  pll_supervisor #(
    .RST_CYCLES(RSTC), .STABLE_CYCLES(STC), .TIMEOUT_CYCLES(TOC), .MAX_RETRIES(MAXR), .LOSS_W(8)
  ) dut (
    .clock_in(clk), .reset(rst), .clock_out(co1), .pll_ready(rdy1), .pll_reset_out(pro1),
    .fault(flt1), .retry_count(rc1), .lock_loss_cnt(llc1)
  );

  pll_supervisor #(
    .RST_CYCLES(RSTC), .STABLE_CYCLES(STC), .TIMEOUT_CYCLES(TOC), .MAX_RETRIES(MAXR), .LOSS_W(2)
  ) dut2 (
    .clock_in(clk), .reset(rst), .clock_out(co2), .pll_ready(rdy2), .pll_reset_out(pro2),
    .fault(flt2), .retry_count(rc2), .lock_loss_cnt(llc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_lock(input bit v);
    lock_drv = v;
    if (v) begin
      force dut.pll_lock  = 1'b1;
      force dut2.pll_lock = 1'b1;
    end else begin
      force dut.pll_lock  = 1'b0;
      force dut2.pll_lock = 1'b0;
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_phase = "rst";
    m_age   = 0;
    m_retry = 0;
    m_loss  = 0;
    m_sync  = {1'b0, 1'b0};
  endtask

  // One clock edge of the rules: LOCK seen two edges late, then phase/age decisions
  task automatic model_edge();
    bit    ls;
    string nxt;
    ls = m_sync.pop_front();
    m_sync.push_back(lock_drv);
    nxt = m_phase;
    if (m_phase == "rst") begin
      if (m_age == RSTC - 1) nxt = "wait";
    end else if (m_phase == "wait") begin
      if (ls) nxt = "stable";
      else if (m_age == TOC - 1) begin
        m_retry++;
        nxt = (m_retry == MAXR) ? "fault" : "rst";
      end
    end else if (m_phase == "stable") begin
      if (!ls) nxt = "wait";
      else if (m_age == STC - 1) begin
        nxt = "ready";
        m_retry = 0;
      end
    end else if (m_phase == "ready") begin
      if (!ls) begin
        m_loss++;
        nxt = "rst";
      end
    end
    m_age   = (nxt == m_phase) ? m_age + 1 : 0;
    m_phase = nxt;
  endtask

  task automatic check_model();
    bit er;
    er = (m_phase == "ready");
    chk("ready",   rdy1, er);
    chk("rst_out", pro1, !er);
    chk("fault",   flt1, m_phase == "fault");
    chk("resetb",  dut.pll_resetb, !(m_phase == "rst" || m_phase == "fault"));
    chk("retry",   rc1, m_retry);
    chk("loss",    llc1, sat(m_loss, 255));
    chk("ready2",  rdy2, er);
    chk("loss2",   llc2, sat(m_loss, 3));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"},   rdy1, 0);
    chk({tag, "_rst_out"}, pro1, 1);
    chk({tag, "_fault"},   flt1, 0);
    chk({tag, "_retry"},   rc1, 0);
    chk({tag, "_loss"},    llc1, 0);
    chk({tag, "_resetb"},  dut.pll_resetb, 0);
    chk({tag, "_loss2"},   llc2, 0);
  endtask

  // Asynchronous reset assertion mid-cycle; outputs must clear without a clock edge
  task automatic do_reset(input string tag);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset_vals(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic wait_ready(input int limit, input string tag);
    int n;
    n = 0;
    while (rdy1 !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    chk({tag, "_ready_reached"}, rdy1, 1);
  endtask

  task automatic wait_phase(input string p, input int limit);
    int n;
    n = 0;
    while (m_phase != p && n < limit) begin
      tick();
      n++;
    end
    chk({"phase_", p, "_reached"}, m_phase == p, 1);
  endtask

  initial begin
    int n;
    rst = 1'b0;
    set_lock(1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("por");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // 1: clean bring-up; RESETB releases after RSTC edges, LOCK 5 cycles later
    n = 0;
    while (dut.pll_resetb !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("t1_resetb_release", n, RSTC);
    repeat (5) tick();
    set_lock(1'b1);
    n = 0;
    while (rdy1 !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    // first sampling edge, then 2 sync edges, then STC stable cycles
    chk("t1_lock_to_ready", n, 1 + 2 + STC);
    chk("t1_retry", rc1, 0);

    // 2: one-cycle LOCK drop while ready
    repeat (3) tick();
    set_lock(1'b0);
    tick();
    set_lock(1'b1);
    n = 0;
    while (rdy1 === 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk("t2_ready_drop", rdy1, 0);
    chk("t2_loss", llc1, 1);
    n = 0;
    while (dut.pll_resetb === 1'b0 && n < 20) begin
      n++;
      tick();
    end
    chk("t2_resetb_low", n, RSTC);
    wait_ready(60, "t2");

    // 3: LOCK never comes; three timeouts then terminal fault
    set_lock(1'b0);
    do_reset("t3_pre");
    n = 0;
    while (flt1 !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    chk("t3_cycles_to_fault", n, MAXR * (RSTC + TOC));
    chk("t3_retry", rc1, MAXR);
    repeat (20) tick();
    chk("t3_resetb_held", dut.pll_resetb, 0);
    chk("t3_fault_sticky", flt1, 1);

    // 6a: reset out of FAULT
    set_lock(1'b1);
    do_reset("t6_fault");

    // 4: LOCK glitch during STABLE (drop at cycle 5)
    wait_phase("stable", 40);
    repeat (5) tick();
    set_lock(1'b0);
    tick();
    set_lock(1'b1);
    n = 0;
    while (rdy1 !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("t4_rise_to_ready", n, 1 + 2 + STC);
    chk("t4_no_loss", llc1, 0);

    // 6b: reset in the middle of STABLE, then clean restart
    do_reset("t6_pre");
    wait_phase("stable", 40);
    repeat (3) tick();
    do_reset("t6_stable");
    wait_ready(60, "t6_restart");

    // 5: four losses from READY; narrow counter saturates
    do_reset("t5_pre");
    for (int k = 0; k < 4; k++) begin
      set_lock(1'b1);
      wait_ready(80, "t5");
      repeat (2) tick();
      set_lock(1'b0);
      tick();
      set_lock(1'b1);
      n = 0;
      while (rdy1 === 1'b1 && n < 10) begin
        tick();
        n++;
      end
    end
    repeat (4) tick();
    chk("t5_loss_sat", llc2, 3);
    chk("t5_loss_wide", llc1, 4);

    // random LOCK waveforms: mostly-high with glitches and long outages
    for (int ep = 0; ep < 12; ep++) begin
      int cyc;
      do_reset("rnd");
      cyc = 0;
      while (cyc < 300) begin
        int len;
        bit v;
        v   = ($urandom_range(0, 3) != 0);
        len = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(6, 45));
        set_lock(v);
        repeat (len) tick();
        cyc += len;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
